// File: rtl/sync_receiver_pkg.sv
// Shared types and constants for the sync reference receiver.
// Lock constants are only consumed when SYNC_RECEIVER_LOCK_EN is defined.
package sync_receiver_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_BOTH = 2'd2
    } edge_mode_e;

    localparam int unsigned LOCK_COUNT = 4;
    localparam int unsigned LOCK_TOL   = 1;
    localparam int unsigned PERIOD_W   = 16;

    localparam logic [PERIOD_W-1:0] LOCK_TOL_V = LOCK_TOL[PERIOD_W-1:0];

    // True when two measured periods differ by no more than the lock tolerance.
    function automatic logic within_tol(input logic [PERIOD_W-1:0] a,
                                        input logic [PERIOD_W-1:0] b);
        logic [PERIOD_W-1:0] diff;
        diff = (a > b) ? (a - b) : (b - a);
        return diff <= LOCK_TOL_V;
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Generic N-stage synchroniser; only the first stage samples the async input.
module sync_ff_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous level through the metastability chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sync_receiver.sv
// Resynchronises an external sync square wave and emits one clk-wide pulse per
// selected edge. Optional lock detector enabled by SYNC_RECEIVER_LOCK_EN.
module sync_receiver
    import sync_receiver_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned EDGE_MODE     = 0,
    parameter int unsigned FILTER_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic sync_pulse
`ifdef SYNC_RECEIVER_LOCK_EN
    ,
    output logic locked
`endif
);

    localparam edge_mode_e Mode = edge_mode_e'(EDGE_MODE[1:0]);

    logic sync_lvl;
    logic acc_lvl;
    logic hist_q;
    logic pulse_q;
    logic rise;
    logic fall;
    logic fire;

    sync_ff_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (sync_in),
        .q_o (sync_lvl)
    );

    if (FILTER_CYCLES == 0) begin : g_nofilt
        assign acc_lvl = sync_lvl;
    end else begin : g_filt
        // Flip happens on the cycle the mismatch count would reach FILTER_CYCLES.
        localparam logic [7:0] CntMax = 8'(FILTER_CYCLES - 1);

        logic [7:0] cnt_q, cnt_d;
        logic       acc_q, acc_d;

        // Count consecutive mismatching cycles; accept the new level once stable.
        always_comb begin
            cnt_d = cnt_q;
            acc_d = acc_q;
            if (sync_lvl == acc_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntMax) begin
                acc_d = ~acc_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        // Filter state register.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
                acc_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                acc_q <= acc_d;
            end
        end

        assign acc_lvl = acc_q;
    end

    // Edge detection on the accepted level against its one-cycle history.
    always_comb begin
        rise = acc_lvl & ~hist_q;
        fall = ~acc_lvl & hist_q;
        fire = 1'b0;
        case (Mode)
            EDGE_RISE: fire = rise;
            EDGE_FALL: fire = fall;
            EDGE_BOTH: fire = rise | fall;
            default:   fire = rise;
        endcase
    end

    // History flop and registered output pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            hist_q  <= acc_lvl;
            pulse_q <= fire;
        end
    end

    assign sync_pulse = pulse_q;

`ifdef SYNC_RECEIVER_LOCK_EN
    localparam logic [PERIOD_W-1:0] PerMax = '1;
    localparam logic [2:0]          RunMax = 3'(LOCK_COUNT);

    logic [PERIOD_W-1:0] per_q, per_d;
    logic [PERIOD_W-1:0] prev_q, prev_d;
    // 0: no rise yet, 1: one rise seen, 2: a previous period is available.
    logic [1:0]          seen_q, seen_d;
    logic [2:0]          run_q, run_d;
    logic                locked_q, locked_d;

    // Measure rise-to-rise periods and track the run of in-tolerance periods.
    always_comb begin
        per_d    = per_q;
        prev_d   = prev_q;
        seen_d   = seen_q;
        run_d    = run_q;
        locked_d = locked_q;
        if (seen_q != 2'd0 && per_q != PerMax) begin
            per_d = per_q + 1'b1;
        end
        if (rise) begin
            per_d = {{(PERIOD_W-1){1'b0}}, 1'b1};
            unique case (seen_q)
                2'd0: seen_d = 2'd1;
                2'd1: begin
                    seen_d = 2'd2;
                    prev_d = per_q;
                    run_d  = 3'd1;
                end
                default: begin
                    prev_d = per_q;
                    if (within_tol(per_q, prev_q)) begin
                        if (run_q != RunMax) begin
                            run_d = run_q + 3'd1;
                        end
                    end else begin
                        run_d = 3'd1;
                    end
                end
            endcase
            locked_d = (run_d == RunMax);
        end else if (seen_q != 2'd0 && per_q == PerMax) begin
            // Reference lost: restart as if no rise had been seen.
            seen_d   = 2'd0;
            run_d    = 3'd0;
            locked_d = 1'b0;
        end
    end

    // Lock detector state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_q    <= '0;
            prev_q   <= '0;
            seen_q   <= 2'd0;
            run_q    <= 3'd0;
            locked_q <= 1'b0;
        end else begin
            per_q    <= per_d;
            prev_q   <= prev_d;
            seen_q   <= seen_d;
            run_q    <= run_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;
`endif

endmodule

// File: tb/tb_sync_receiver.sv
// Bench for sync_receiver: four configurations share one stimulus, checked every
// cycle against a timeline model of sampled sync_in. Lock checks need SYNC_RECEIVER_LOCK_EN.
module tb_sync_receiver;

    localparam int NI   = 4;
    localparam int MAXC = 4096;
    localparam int S_P [NI] = '{2, 2, 2, 3};
    localparam int E_P [NI] = '{0, 2, 0, 1};
    localparam int F_P [NI] = '{0, 0, 3, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sync_in = 1'b0;
    logic [NI-1:0] pulse;
`ifdef SYNC_RECEIVER_LOCK_EN
    logic [NI-1:0] lock;
`endif

    always #5 clk = ~clk;

    sync_receiver #(.SYNC_STAGES(2), .EDGE_MODE(0), .FILTER_CYCLES(0)) u_rise (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (sync_in),
        .sync_pulse (pulse[0])
`ifdef SYNC_RECEIVER_LOCK_EN
        ,
        .locked     (lock[0])
`endif
    );

    sync_receiver #(.SYNC_STAGES(2), .EDGE_MODE(2), .FILTER_CYCLES(0)) u_both (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (sync_in),
        .sync_pulse (pulse[1])
`ifdef SYNC_RECEIVER_LOCK_EN
        ,
        .locked     (lock[1])
`endif
    );

    sync_receiver #(.SYNC_STAGES(2), .EDGE_MODE(0), .FILTER_CYCLES(3)) u_filt (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (sync_in),
        .sync_pulse (pulse[2])
`ifdef SYNC_RECEIVER_LOCK_EN
        ,
        .locked     (lock[2])
`endif
    );

    sync_receiver #(.SYNC_STAGES(3), .EDGE_MODE(1), .FILTER_CYCLES(2)) u_s3fall (
        .clk        (clk),
        .rst        (rst),
        .sync_in    (sync_in),
        .sync_pulse (pulse[3])
`ifdef SYNC_RECEIVER_LOCK_EN
        ,
        .locked     (lock[3])
`endif
    );

    // Model: smpa[n] is the sync_in level captured at edge n since reset release.
    bit        smpa [MAXC];
    bit        lfa  [NI][MAXC];
    int        cyc;
    bit [NI-1:0] expv;
    bit        exp_lock;
    int        last_rise;
    int        periods[$];

    int total = 0;
    int bad   = 0;
    int cnt_p  [NI];
    int runlen [NI];
    int maxrun [NI];
    int lock_on[$];
    int lock_off[$];
    bit lock_prev;

    function automatic bit smp_at(input int i);
        return (i < 0) ? 1'b0 : smpa[i];
    endfunction

    // Synchronised level after edge m.
    function automatic bit raw_at(input int n, input int m);
        return smp_at(m - S_P[n] + 1);
    endfunction

    // Accepted (filtered) level after edge m.
    function automatic bit acc_at(input int n, input int m);
        if (m < 0) return 1'b0;
        if (F_P[n] == 0) return raw_at(n, m);
        return lfa[n][m];
    endfunction

    task automatic model_reset();
        cyc = 0;
        expv = '0;
        exp_lock = 1'b0;
        last_rise = -1;
        periods.delete();
    endtask

    task automatic model_step();
        bit cur, prv, all;
        int run, d;
        if (!rst) begin
            model_reset();
        end else begin
            if (cyc >= MAXC) begin
                $display("FAIL model_overflow cyc=%0d limit=%0d", cyc, MAXC);
                $fatal(1);
            end
            smpa[cyc] = sync_in;
            for (int n = 0; n < NI; n++) begin
                cur = acc_at(n, cyc - 1);
                prv = acc_at(n, cyc - 2);
                case (E_P[n])
                    0:       expv[n] = cur & ~prv;
                    1:       expv[n] = ~cur & prv;
                    default: expv[n] = cur ^ prv;
                endcase
                if (F_P[n] > 0) begin
                    // Level accepted only after F consecutive differing samples.
                    all = 1'b1;
                    for (int j = 1; j <= F_P[n]; j++) begin
                        if (raw_at(n, cyc - j) == cur) all = 1'b0;
                    end
                    lfa[n][cyc] = all ? ~cur : cur;
                end
            end
            if (acc_at(0, cyc - 1) && !acc_at(0, cyc - 2)) begin
                if (last_rise >= 0) begin
                    periods.push_back(cyc - last_rise);
                    run = 1;
                    for (int k = periods.size() - 1; k > 0; k--) begin
                        d = periods[k] - periods[k-1];
                        if (d <= 1 && d >= -1) run++;
                        else break;
                    end
                    exp_lock = (run >= 4);
                end
                last_rise = cyc;
            end
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic ex);
        total++;
        assert (obs === ex) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, ex, $time);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int ex);
        total++;
        assert (obs === ex) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, ex, $time);
        end
    endtask

    task automatic check_all();
        for (int n = 0; n < NI; n++) chk($sformatf("pulse%0d", n), pulse[n], expv[n]);
`ifdef SYNC_RECEIVER_LOCK_EN
        chk("locked", lock[0], exp_lock);
`endif
    endtask

    task automatic clr_cnt();
        for (int n = 0; n < NI; n++) begin
            cnt_p[n] = 0;
            runlen[n] = 0;
            maxrun[n] = 0;
        end
    endtask

    // One clock: model at the rising edge, compare at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        for (int n = 0; n < NI; n++) begin
            cnt_p[n] += int'(pulse[n]);
            runlen[n] = pulse[n] ? runlen[n] + 1 : 0;
            if (runlen[n] > maxrun[n]) maxrun[n] = runlen[n];
        end
`ifdef SYNC_RECEIVER_LOCK_EN
        if (lock[0] && !lock_prev) lock_on.push_back(cnt_p[0]);
        if (!lock[0] && lock_prev) lock_off.push_back(cnt_p[0]);
        lock_prev = lock[0];
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset from a falling edge; outputs must clear at once.
    task automatic do_reset(input int hold);
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        ticks(hold);
        rst = 1'b1;
    endtask

    // Raise sync_in for 'hold' cycles; report first pulse cycle of u_rise/u_filt.
    task automatic measure(input int hold, output int f0, output int f2, output int h0);
        f0 = -1;
        f2 = -1;
        h0 = 0;
        sync_in = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            if (pulse[0] && f0 < 0) f0 = n;
            if (pulse[2] && f2 < 0) f2 = n;
            h0 += int'(pulse[0]);
            if (n == hold) sync_in = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time=%0t limit=1000000", $time);
        $fatal(1);
    end

    initial begin
        int f0, f2, h0;
        model_reset();
        clr_cnt();
        lock_prev = 1'b0;

        // Reset held with sync_in toggling, then release with sync_in low.
        #2;
        rst = 1'b0;
        #1;
        check_all();
        for (int i = 0; i < 10; i++) begin
            sync_in = ~sync_in;
            tick();
        end
        sync_in = 1'b0;
        rst = 1'b1;
        ticks(10);
        chk_int("quiet_count_rise", cnt_p[0], 0);
        chk_int("quiet_count_both", cnt_p[1], 0);

        // Single rise: 3-edge latency unfiltered, +3 with FILTER_CYCLES=3.
        measure(14, f0, f2, h0);
        chk_int("latency_rise", f0, 3);
        chk_int("latency_filt", f2, 6);
        chk_int("width_rise", h0, 1);

        // Ten periods of a 20-cycle square wave.
        sync_in = 1'b0;
        ticks(20);
        clr_cnt();
        for (int p = 0; p < 10; p++) begin
            sync_in = 1'b1;
            ticks(10);
            sync_in = 1'b0;
            ticks(10);
        end
        ticks(10);
        chk_int("periodic_rise", cnt_p[0], 10);
        chk_int("periodic_both", cnt_p[1], 20);
        chk_int("periodic_filt", cnt_p[2], 10);
        chk_int("periodic_fall", cnt_p[3], 10);
        chk_int("periodic_width_both", maxrun[1], 1);
        chk_int("periodic_width_rise", maxrun[0], 1);

        // Glitch filter: 2-cycle level rejected, 4-cycle level accepted.
        clr_cnt();
        measure(2, f0, f2, h0);
        chk_int("glitch_unfilt_seen", f0, 3);
        chk_int("glitch_filt_reject", f2, -1);
        measure(4, f0, f2, h0);
        chk_int("level4_unfilt", f0, 3);
        chk_int("level4_filt", f2, 6);

        // Reset one cycle after sync_in rises: in-flight pulse dropped.
        ticks(10);
        clr_cnt();
        sync_in = 1'b1;
        ticks(2);
        sync_in = 1'b0;
        do_reset(3);
        ticks(10);
        chk_int("midreset_drop", cnt_p[0], 0);
        sync_in = 1'b1;
        ticks(10);
        chk_int("midreset_resume", cnt_p[0], 1);

        // Randomised levels with occasional asynchronous resets.
        for (int seg = 0; seg < 120; seg++) begin
            sync_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
            ticks($urandom_range(1, 12));
        end

`ifdef SYNC_RECEIVER_LOCK_EN
        // Lock: steady 20-cycle period, one 25-cycle period, then relock.
        sync_in = 1'b0;
        do_reset(2);
        ticks(5);
        clr_cnt();
        lock_on.delete();
        lock_off.delete();
        for (int p = 1; p <= 12; p++) begin
            sync_in = 1'b1;
            ticks(10);
            sync_in = 1'b0;
            ticks((p == 6) ? 15 : 10);
        end
        ticks(10);
        chk_int("lock_on_events", lock_on.size(), 2);
        chk_int("lock_off_events", lock_off.size(), 1);
        if (lock_on.size() == 2 && lock_off.size() == 1) begin
            chk_int("lock_first_rise", lock_on[0], 5);
            chk_int("lock_drop_rise", lock_off[0], 7);
            chk_int("relock_rise", lock_on[1], 11);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_receiver.md
Name: sync_receiver

Overview:
- Receives an external, asynchronous square-wave sync reference (`sync_in`) from another board or FPGA.
- Resynchronises it into the local `clk` domain and emits one single-cycle `sync_pulse` per selected edge.
- Downstream phase/emitter logic uses `sync_pulse` to realign its local counters to the shared reference.

Parameters:
- SYNC_STAGES, 2, number of metastability flops (legal 2..4).
- EDGE_MODE, 0, edge that fires a pulse: 0 = rising, 1 = falling, 2 = both.
- FILTER_CYCLES, 0, glitch filter: a new level must be stable this many consecutive synchronised cycles before it is accepted. 0 disables the filter (legal 0..255).

Ports:
- clk  input  1  system clock; all flops on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- sync_in  input  1  asynchronous sync reference; no timing relationship to clk.
- sync_pulse  output  1  registered single-cycle pulse per accepted edge.

Behaviour:
- Reset (rst=0, asynchronous):
  - all synchroniser, filter and history flops clear to 0;
  - sync_pulse = 0 immediately.
  - Because history resets to 0, a sync_in already high at reset release produces one rising-edge pulse after the normal latency.
- Synchroniser: SYNC_STAGES-deep shift register clocked by clk; sync_in is sampled only by stage 1.
- Filter, FILTER_CYCLES=0: accepted level = synchroniser output, no added delay.
- Filter, FILTER_CYCLES=N>0:
  - a counter increments while the synchroniser output differs from the accepted level, and resets to 0 when they match;
  - when the counter reaches N, the accepted level flips and the counter clears;
  - pulses shorter than N cycles never appear;
  - total latency grows by N cycles.
- Edge detect: history flop holds the previous accepted level. Edge-detect logic looks at current accepted level vs history:
  - rise: current=1, history=0;
  - fall: current=0, history=1;
  - EDGE_MODE selects rise, fall or rise|fall.
- sync_pulse is registered from the edge-detect result:
  - high for exactly one clk cycle per accepted edge, never longer;
  - back-to-back edges on consecutive cycles give consecutive pulses.
- Latency (FILTER_CYCLES=0):
  - let posedge k be the first clk edge at which stage 1 captures the new sync_in level;
  - sync_pulse rises after posedge k+SYNC_STAGES and falls after posedge k+SYNC_STAGES+1;
  - default is a 3-edge latency, 1-cycle width.
- Edge period is unconstrained: any period of at least 2 clk cycles (with filter off) yields one pulse per edge, with no missed or merged pulses.
- Reset mid-operation: pulse in flight is dropped; behaviour after release is as from power-up.
- No pulse is generated by reset release itself unless sync_in is high (rising case above).

Optional Feature:
- Macro: SYNC_RECEIVER_LOCK_EN.
- With the macro defined, added output `locked` (1 bit, resets 0) and internal 16-bit period counter:
  - the counter counts clk cycles between successive rising accepted edges;
  - locked=1 after 4 consecutive periods differ from the previous period by at most 1 cycle;
  - locked=0 on any period outside tolerance, or if the counter saturates at 16'hFFFF.
  - locked has the same registered timing as sync_pulse.
- Without the macro: no `locked` port, no counter logic, and sync_pulse behaviour is identical either way.

Decomposition:
- Package sync_receiver_pkg:
  - edge_mode_e enum (EDGE_RISE=0, EDGE_FALL=1, EDGE_BOTH=2);
  - lock constants LOCK_COUNT=4, LOCK_TOL=1, PERIOD_W=16.
- Sub-module: sync_ff_chain (generic N-stage asynchronous-reset synchroniser, parameter STAGES), instantiated once.
- Filter, edge detect and lock logic stay in the top module.

Test Plan:
- Reset: hold rst=0 with sync_in toggling -> sync_pulse stays 0; release rst with sync_in=0 -> no pulse.
- Latency, defaults, clk period 2 units, sync_in period 20 units:
  - rst released at t=4, sync_in rises at t=12;
  - sync_pulse=1 in the cycle after t=18 edge, 0 after t=20;
  - exactly one pulse per rising edge over 10 periods.
- EDGE_MODE=2, same stimulus -> one pulse per rising and per falling edge, 20 pulses in 10 periods, each 1 cycle wide.
- FILTER_CYCLES=3:
  - 2-cycle high glitch on sync_in -> no pulse;
  - 4-cycle high level -> one pulse, 3 cycles later than the unfiltered case.
- Reset mid-operation: assert rst=0 one cycle after sync_in rises -> no pulse; after release behaviour resumes normally on the next edge.
- SYNC_RECEIVER_LOCK_EN:
  - steady 20-cycle period -> locked=1 after the 5th rising edge;
  - one period changed to 25 cycles -> locked=0 at that edge, relocks after 4 good periods.
